// File: rtl/demux8_collector_if.sv
// -----------------------------------------------------------------------------
// demux8_collector_if
//   Output handshake between the collector and the frame consumer.
//   q       : last completed 8-bit frame (q[i] = bit captured in slot i)
//   q_valid : q holds a frame the consumer has not yet acknowledged
//   q_ack   : consumer acknowledge, honoured while q_valid is high
//   master  : collector side (drives q/q_valid, samples q_ack)
//   slave   : consumer side (samples q/q_valid, drives q_ack)
// -----------------------------------------------------------------------------
interface demux8_collector_if;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ack;

    modport master (output q, output q_valid, input q_ack);
    modport slave  (input q, input q_valid, output q_ack);
endinterface

// File: rtl/demux8_collector.sv
// -----------------------------------------------------------------------------
// demux8_collector
//   Drives the select lines of an upstream 8-to-1 multiplexer and reassembles
//   the serialised bits into an 8-bit frame.
//   clk     : system clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   E       : enable; when low, only q_ack is honoured
//   start   : begins (or restarts) a frame at slot 0
//   d       : serial bit from the upstream mux
//   valid   : qualifies d for the current slot
//   sel     : current slot index, drives the upstream mux selects
//   slot    : one-hot of sel while collecting and enabled, else zero
//   busy    : high while collecting
//   overrun : sticky, a frame overwrote an unacknowledged one
//   frame   : q / q_valid / q_ack handshake to the consumer
// -----------------------------------------------------------------------------
module demux8_collector (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      E,
    input  logic                      start,
    input  logic                      d,
    input  logic                      valid,
    output logic [2:0]                sel,
    output logic [7:0]                slot,
    output logic                      busy,
    output logic                      overrun,
    demux8_collector_if.master        frame
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] sel_r, sel_nxt;
    logic [7:0] shadow, shadow_nxt;
    logic [7:0] q_r, q_nxt;
    logic       q_valid_r, q_valid_nxt;
    logic       overrun_r, overrun_nxt;
    logic       complete;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel_r     <= 3'd0;
            shadow    <= 8'h00;
            q_r       <= 8'h00;
            q_valid_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_r     <= sel_nxt;
            shadow    <= shadow_nxt;
            q_r       <= q_nxt;
            q_valid_r <= q_valid_nxt;
            overrun_r <= overrun_nxt;
        end
    end

    // NOTE: every output of this block is given its hold value first, so no
    // path through the case/if tree can leave a latch behind.
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_r;
        shadow_nxt  = shadow;
        q_nxt       = q_r;
        q_valid_nxt = q_valid_r;
        overrun_nxt = overrun_r;
        complete    = 1'b0;

        if (E) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt  = COLLECT;
                        sel_nxt    = 3'd0;
                        shadow_nxt = 8'h00;
                    end
                end
                COLLECT: begin
                    // start beats valid: the bit on d in a restart cycle is dropped
                    if (start) begin
                        sel_nxt    = 3'd0;
                        shadow_nxt = 8'h00;
                    end else if (valid) begin
                        shadow_nxt[sel_r] = d;
                        if (sel_r == 3'd7) begin
                            complete  = 1'b1;
                            state_nxt = IDLE;
                            sel_nxt   = 3'd0;
                        end else begin
                            sel_nxt = sel_r + 3'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // A completing frame takes priority over a same-cycle acknowledge.
        if (complete) begin
            q_nxt       = {d, shadow[6:0]};
            q_valid_nxt = 1'b1;
            if (q_valid_r && !frame.q_ack)
                overrun_nxt = 1'b1;
        end else if (q_valid_r && frame.q_ack) begin
            q_valid_nxt = 1'b0;
        end
    end

    assign sel           = sel_r;
    assign busy          = (state == COLLECT);
    assign slot          = (state == COLLECT && E) ? (8'h01 << sel_r) : 8'h00;
    assign overrun       = overrun_r;
    assign frame.q       = q_r;
    assign frame.q_valid = q_valid_r;

endmodule

// File: doc/demux8_collector.md
DEMUX8_COLLECTOR -- requirements
Module: demux8_collector

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 E  input  1  enable; when 0, all state except reset holds (sel, shadow, state frozen).
REQ-004 start  input  1  frame start; begins or restarts a frame at slot 0.
REQ-005 d  input  1  serial data bit from the upstream 8-to-1 multiplexer.
REQ-006 valid  input  1  qualifies d for the current slot.
REQ-007 q_ack  input  1  consumer acknowledge for q/q_valid.
REQ-008 sel  output  3  current slot index; drives the upstream mux selects (sel[0]=s0, sel[1]=s1, sel[2]=s2).
REQ-009 slot  output  8  one-hot decode of sel, gated by state COLLECT and E; all zero otherwise.
REQ-010 busy  output  1  high while state is COLLECT.
REQ-011 q  output  8  last completed frame; q[i] = bit captured at sel=i.
REQ-012 q_valid  output  1  q holds an unacknowledged frame.
REQ-013 overrun  output  1  sticky; a frame completed while q_valid was high and not acknowledged.

Function
REQ-014 Two states, IDLE and COLLECT; 3-bit slot counter sel; 8-bit shadow register.
REQ-015 IDLE: sel=0; on E=1 and start=1, go to COLLECT with sel=0 and shadow=0; no bit is captured in the start cycle.
REQ-016 IDLE: valid without start is ignored.
REQ-017 COLLECT, E=1, start=0, valid=1: shadow[sel]<=d; if sel<7, sel<=sel+1.
REQ-018 COLLECT, sel=7, capture cycle: q<={d, shadow[6:0]}, q_valid<=1, sel<=0, state<=IDLE, in the same edge.
REQ-019 COLLECT, valid=0: sel and shadow hold; no timeout.
REQ-020 COLLECT, start=1 and E=1: abort current frame; sel<=0, shadow<=0, stay in COLLECT; start has priority over valid in the same cycle (d discarded); q and q_valid unchanged.
REQ-021 E=0: start, valid and d are ignored; q_ack is still honoured.
REQ-022 Latency: q/q_valid updated on the clock edge that samples the 8th valid bit; q_valid is visible the following cycle.
REQ-023 q_ack=1 with q_valid=1 and no completion in that cycle: q_valid<=0; q holds its value.
REQ-024 Completion and q_ack in the same cycle: new frame wins; q_valid stays 1, q takes new data, overrun unchanged.
REQ-025 Completion with q_valid=1 and q_ack=0: q overwritten, q_valid stays 1, overrun<=1.
REQ-026 overrun is cleared only by reset.
REQ-027 q_ack with q_valid=0 has no effect.
REQ-028 slot, busy and sel are derived from registered state only; no combinational path from inputs to outputs except E into slot.

Reset
REQ-029 reset_n=0 asynchronously forces state=IDLE, sel=0, shadow=0, q=8'h00, q_valid=0, overrun=0; slot=0, busy=0.
REQ-030 Reset asserted mid-frame discards the partial frame; after release, the block waits in IDLE for start.
REQ-031 Reset release is synchronous to clk in effect: the first state change is on the first rising edge with reset_n=1.

Verification
REQ-032 Reset, E=1, start pulse, then 8 valid bits 1,0,1,0,0,1,0,1 -> q=8'hA5, q_valid=1 after 8th edge, busy=0, sel=0, overrun=0.
REQ-033 Mid-frame start after 3 bits, then 8 bits of 8'h3C -> q=8'h3C; first 3 bits discarded; sel reads 0 the cycle after start.
REQ-034 Frame 8'hA5 unacked, second frame 8'h5A completes -> q=8'h5A, q_valid=1, overrun=1; q_ack then -> q_valid=0, overrun stays 1.
REQ-035 q_ack asserted on the completing edge of frame 8'hFF with prior frame pending -> q=8'hFF, q_valid=1, overrun=0.
REQ-036 E=0 for 4 cycles with valid=1 at sel=4 -> sel stays 4, slot=8'h00, shadow unchanged; E=1 resumes at sel=4.
REQ-037 reset_n low between clock edges at sel=5 -> sel=0, busy=0, q_valid=0 immediately, without waiting for a clock edge.
